// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronizes raw lines, latches pending sources,
// and presents one fixed-priority request with its ID until the core acknowledges it.
module ext_int_ctrl #(
    parameter int                 NUM_SRC     = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
    parameter int                 ID_BASE     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] src_en_i,
    input  logic               global_int_en_i,
    input  logic               int_ack_i,
    input  logic               mret_done_i,
    output logic               int_req_o,
    output logic [7:0]         int_id_o,
    output logic [NUM_SRC-1:0] pending_o
);

    localparam int         IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [7:0] ID_BASE8 = 8'(ID_BASE);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_REQ  = 3'b010,
        S_SVC  = 3'b100
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] s_d_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] clr;
    logic [IDX_W-1:0]   cand_idx, idx_q;
    logic               cand_vld;
    logic               take;
    logic [7:0]         id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= irq_src_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Ack only clears the edge-latched bit of the source currently being served.
    always_comb begin
        clr = '0;
        if (state_q == S_REQ && int_ack_i) begin
            clr[idx_q] = 1'b1;
        end
    end

    assign pending_d = (EDGE_MASK & ((s & ~s_d_q) | (pending_q & ~clr)))
                     | (~EDGE_MASK & s);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_q     <= '0;
            pending_q <= '0;
        end else begin
            s_d_q     <= s;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!cand_vld && pending_q[i] && src_en_i[i]) begin
                cand_vld = 1'b1;
                cand_idx = IDX_W'(i);
            end
        end
    end

    assign take = (state_q == S_IDLE) && global_int_en_i && cand_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (take) state_d = S_REQ;
            S_REQ: begin
                if (int_ack_i)             state_d = S_SVC;
                else if (!global_int_en_i) state_d = S_IDLE;
            end
            S_SVC:  if (mret_done_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ID is captured once on entry to S_REQ so later pending/enable changes cannot move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            id_q  <= '0;
        end else if (take) begin
            idx_q <= cand_idx;
            id_q  <= ID_BASE8 + 8'(cand_idx);
        end
    end

    always_comb begin
        int_req_o = (state_q == S_REQ);
        int_id_o  = (state_q == S_REQ) ? id_q : '0;
        pending_o = pending_q;
    end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Scoreboard bench for ext_int_ctrl: directed scenarios then random traffic,
// checked against a raw-history reference model.
module tb_ext_int_ctrl;

    localparam int         NS  = 8;
    localparam int         SS  = 2;
    localparam int         IDB = 16;
    localparam logic [7:0] EM  = 8'hA2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq, en;
    logic       gie, ack, mret;
    logic       req;
    logic [7:0] id;
    logic [7:0] pend;

    ext_int_ctrl #(
        .NUM_SRC    (NS),
        .SYNC_STAGES(SS),
        .EDGE_MASK  (EM),
        .ID_BASE    (IDB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src_i      (irq),
        .src_en_i       (en),
        .global_int_en_i(gie),
        .int_ack_i      (ack),
        .mret_done_i    (mret),
        .int_req_o      (req),
        .int_id_o       (id),
        .pending_o      (pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic [7:0] id;
        logic [7:0] pend;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] hist[$];
    logic [7:0] m_pend;
    int         m_mode;
    int         m_cur;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    // Reference: hist[k] is the raw input seen k edges ago; modes 0 idle, 1 request, 2 service.
    function automatic void model_step(input logic [7:0] i_irq, i_en,
                                       input logic i_gie, i_ack, i_mret, i_rst);
        logic [7:0] s, sd, np;
        int cand;
        if (i_rst) begin
            hist.delete();
            for (int k = 0; k < SS + 2; k++) hist.push_back(8'h00);
            m_pend = 8'h00;
            m_mode = 0;
            m_cur  = 0;
            return;
        end
        hist.push_front(i_irq);
        void'(hist.pop_back());
        s  = hist[SS];
        sd = hist[SS+1];
        cand = -1;
        for (int i = 0; i < NS; i++)
            if (cand < 0 && m_pend[i] && i_en[i]) cand = i;
        for (int i = 0; i < NS; i++) begin
            if (EM[i])
                np[i] = (s[i] & ~sd[i]) | (m_pend[i] & !(m_mode == 1 && i_ack && m_cur == i));
            else
                np[i] = s[i];
        end
        case (m_mode)
            0: if (i_gie && cand >= 0) begin m_mode = 1; m_cur = cand; end
            1: if (i_ack) m_mode = 2; else if (!i_gie) m_mode = 0;
            default: if (i_mret) m_mode = 0;
        endcase
        m_pend = np;
    endfunction

    task automatic drive(input logic [7:0] i_irq, i_en,
                         input logic i_gie, i_ack, i_mret, i_rst);
        exp_t e;
        irq = i_irq; en = i_en; gie = i_gie; ack = i_ack; mret = i_mret; rst = i_rst;
        model_step(i_irq, i_en, i_gie, i_ack, i_mret, i_rst);
        e.req  = (m_mode == 1);
        e.id   = (m_mode == 1) ? 8'(IDB + m_cur) : 8'h00;
        e.pend = m_pend;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [7:0] i_irq, i_en, input logic i_gie);
        repeat (n) drive(i_irq, i_en, i_gie, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("int_req_o", int'(req), int'(e.req));
                check("int_id_o", int'(id), int'(e.id));
                check("pending_o", int'(pend), int'(e.pend));
            end
        end
    end

    initial begin
        logic [7:0] r_irq, r_en;
        logic       r_gie, r_ack, r_mret, r_rst;
        irq = '0; en = '0; gie = 1'b0; ack = 1'b0; mret = 1'b0; rst = 1'b1;
        repeat (2) drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // T1 level source 3 -> id 19 four edges after the rise
        run(5, 8'h08, 8'h08, 1'b1);
        drive(8'h08, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
        run(3, 8'h00, 8'h08, 1'b1);
        drive(8'h00, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0);
        run(2, 8'h00, 8'hFF, 1'b1);

        // T2 lines 5 (edge) and 2 (level) rise together
        run(6, 8'h24, 8'hFF, 1'b1);
        drive(8'h24, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run(3, 8'h20, 8'hFF, 1'b1);
        drive(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run(3, 8'h00, 8'hFF, 1'b1);
        drive(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

        // T3 edge line 1: pulse, ack, second pulse during service
        drive(8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run(5, 8'h00, 8'hFF, 1'b1);
        drive(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4, 8'h00, 8'hFF, 1'b1);
        drive(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run(3, 8'h00, 8'hFF, 1'b1);
        drive(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

        // T4 gating and withdrawal
        run(6, 8'h01, 8'h01, 1'b0);
        run(3, 8'h01, 8'h01, 1'b1);
        run(3, 8'h01, 8'h01, 1'b0);
        run(3, 8'h01, 8'h01, 1'b1);
        drive(8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);

        // T5 frozen ID while a higher source appears and the current one is disabled
        run(6, 8'h08, 8'h08, 1'b1);
        run(4, 8'h09, 8'h01, 1'b1);
        drive(8'h09, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        run(4, 8'h00, 8'hFF, 1'b1);

        // T6 reset in request and in service
        run(6, 8'h10, 8'hFF, 1'b1);
        drive(8'h10, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        run(6, 8'h10, 8'hFF, 1'b1);
        drive(8'h10, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8'h10, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        run(2, 8'h00, 8'hFF, 1'b1);

        r_irq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r_irq = r_irq ^ 8'($urandom());
            r_en   = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'hFF;
            r_gie  = ($urandom_range(0, 7) != 0);
            r_ack  = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            r_mret = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            r_rst  = ($urandom_range(0, 299) == 0);
            drive(r_irq, r_en, r_gie, r_ack, r_mret, r_rst);
        end

        @(posedge clk);
        #5;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
